// File: rtl/foc_pkg.sv
// Shared constants and types for the FOC PID coefficient writer path.
// Holds default parameter values, coefficient indices and the loader state encoding.
package foc_pkg;

    localparam int DEF_D_WIDTH   = 19;
    localparam int DEF_Q_BITS    = 15;
    localparam int DEF_NUM_COEF  = 4;
    localparam bit DEF_AUTO_LOAD = 1'b1;

    typedef enum logic [1:0] {
        COEF_KP   = 2'd0,
        COEF_KI   = 2'd1,
        COEF_KD   = 2'd2,
        COEF_KAUX = 2'd3
    } coef_idx_e;

    // Defaults are powers of two below unity: Kp = 2^-3, Ki = 2^-6 in Q(Q_BITS).
    localparam int KP_DEFAULT_SHIFT = 3;
    localparam int KI_DEFAULT_SHIFT = 6;

    localparam logic [1:0] MASK_NONE = 2'b00;
    localparam logic [1:0] MASK_BOTH = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_IDLE,
        ST_WRITE,
        ST_DONE
    } loader_state_e;

    function automatic int default_coef(input int idx, input int q_bits);
        if (idx == int'(COEF_KP)) return 1 << (q_bits - KP_DEFAULT_SHIFT);
        if (idx == int'(COEF_KI)) return 1 << (q_bits - KI_DEFAULT_SHIFT);
        return 0;
    endfunction

endpackage

// File: rtl/pid_coef_shadow.sv
// Host-programmable shadow table: 2 banks (d, q) x NUM_COEF coefficients.
// One synchronous write port, two combinational read ports sharing one index.
module pid_coef_shadow #(
    parameter int D_WIDTH  = foc_pkg::DEF_D_WIDTH,
    parameter int Q_BITS   = foc_pkg::DEF_Q_BITS,
    parameter int NUM_COEF = foc_pkg::DEF_NUM_COEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic                        wr_bank,
    input  logic [$clog2(NUM_COEF)-1:0] wr_addr,
    input  logic [D_WIDTH-1:0]          wr_data,
    input  logic [$clog2(NUM_COEF)-1:0] rd_addr,
    output logic [D_WIDTH-1:0]          rd_d_data,
    output logic [D_WIDTH-1:0]          rd_q_data
);
    import foc_pkg::*;

    logic [D_WIDTH-1:0] mem_q [2][NUM_COEF];
    logic [D_WIDTH-1:0] mem_d [2][NUM_COEF];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_bank][wr_addr] = wr_data;
        end
    end

    // NOTE: this table is deliberately reset -- the core must receive usable
    // gains on the first commit even if the host never programs anything.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NUM_COEF; i++) begin
                    mem_q[b][i] <= D_WIDTH'(default_coef(i, Q_BITS));
                end
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_d_data = mem_q[0][rd_addr];
    assign rd_q_data = mem_q[1][rd_addr];

endmodule

// File: rtl/pid_coef_loader.sv
// Streams the shadow coefficient table into the core's PID register files
// once the control loop is idle; all core-facing outputs are registered.
module pid_coef_loader #(
    parameter int D_WIDTH   = foc_pkg::DEF_D_WIDTH,
    parameter int Q_BITS    = foc_pkg::DEF_Q_BITS,
    parameter int NUM_COEF  = foc_pkg::DEF_NUM_COEF,
    parameter bit AUTO_LOAD = foc_pkg::DEF_AUTO_LOAD
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        host_wr,
    input  logic                        host_bank,
    input  logic [$clog2(NUM_COEF)-1:0] host_addr,
    input  logic [D_WIDTH-1:0]          host_data,
    output logic                        host_ready,
    input  logic                        commit,
    input  logic [1:0]                  commit_mask,
    input  logic                        ctrl_idle,
    output logic                        hold,
    output logic                        busy,
    output logic                        done,
    output logic                        pid_d_wen,
    output logic                        pid_q_wen,
    output logic [D_WIDTH-1:0]          pid_d_addr,
    output logic [D_WIDTH-1:0]          pid_q_addr,
    output logic [D_WIDTH-1:0]          pid_d_data,
    output logic [D_WIDTH-1:0]          pid_q_data
);
    import foc_pkg::*;

    localparam int            AW         = $clog2(NUM_COEF);
    localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_COEF - 1);
    localparam logic [AW:0]   NUM_COEF_W = (AW + 1)'(NUM_COEF);

    loader_state_e state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [1:0]    mask_q, mask_d;
    logic [1:0]    pend_mask_q, pend_mask_d;
    logic          boot_q, boot_d;

    logic               d_wen_q, d_wen_d, q_wen_q, q_wen_d;
    logic [D_WIDTH-1:0] d_addr_q, d_addr_d, q_addr_q, q_addr_d;
    logic [D_WIDTH-1:0] d_data_q, d_data_d, q_data_q, q_data_d;
    logic               hold_q, hold_d, busy_q, busy_d, done_q, done_d;
    logic               host_ready_q, host_ready_d;

    logic               commit_vld;
    logic               pending;
    logic               shadow_wr;
    logic [D_WIDTH-1:0] shadow_d_rd, shadow_q_rd;
    logic [D_WIDTH-1:0] addr_ext;

    assign commit_vld = commit && (|commit_mask);
    // A non-zero pending mask is the pending flag; commits arriving while busy merge here.
    assign pending    = |pend_mask_q;
    assign shadow_wr  = host_wr && host_ready_q && ({1'b0, host_addr} < NUM_COEF_W);

    pid_coef_shadow #(
        .D_WIDTH  (D_WIDTH),
        .Q_BITS   (Q_BITS),
        .NUM_COEF (NUM_COEF)
    ) u_shadow (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (shadow_wr),
        .wr_bank   (host_bank),
        .wr_addr   (host_addr),
        .wr_data   (host_data),
        .rd_addr   (cnt_d),
        .rd_d_data (shadow_d_rd),
        .rd_q_data (shadow_q_rd)
    );

    always_comb begin
        // NOTE: every _d takes its hold value before the case, so no branch can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        pend_mask_d = pend_mask_q;
        boot_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (boot_q || commit_vld) begin
                    state_d = ST_WAIT_IDLE;
                    mask_d  = (commit_vld ? commit_mask : MASK_NONE) | (boot_q ? MASK_BOTH : MASK_NONE);
                end
            end
            ST_WAIT_IDLE: begin
                if (commit_vld) begin
                    pend_mask_d = pend_mask_q | commit_mask;
                end
                if (ctrl_idle) begin
                    state_d = ST_WRITE;
                    cnt_d   = '0;
                end
            end
            ST_WRITE: begin
                if (commit_vld) begin
                    pend_mask_d = pend_mask_q | commit_mask;
                end
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                pend_mask_d = MASK_NONE;
                if (pending || commit_vld) begin
                    state_d = ST_WAIT_IDLE;
                    mask_d  = pend_mask_q | (commit_vld ? commit_mask : MASK_NONE);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state so the first wen-low cycle
    // coincides with the first WRITE cycle.
    always_comb begin
        addr_ext     = {{(D_WIDTH - AW){1'b0}}, cnt_d};
        d_wen_d      = 1'b1;
        q_wen_d      = 1'b1;
        d_addr_d     = '0;
        q_addr_d     = '0;
        d_data_d     = '0;
        q_data_d     = '0;
        busy_d       = (state_d == ST_WAIT_IDLE) || (state_d == ST_WRITE);
        hold_d       = busy_d;
        done_d       = (state_d == ST_DONE);
        host_ready_d = (state_d == ST_IDLE);
        if (state_d == ST_WRITE) begin
            if (mask_d[0]) begin
                d_wen_d  = 1'b0;
                d_addr_d = addr_ext;
                d_data_d = shadow_d_rd;
            end
            if (mask_d[1]) begin
                q_wen_d  = 1'b0;
                q_addr_d = addr_ext;
                q_data_d = shadow_q_rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            mask_q       <= MASK_NONE;
            pend_mask_q  <= MASK_NONE;
            boot_q       <= AUTO_LOAD;
            d_wen_q      <= 1'b1;
            q_wen_q      <= 1'b1;
            d_addr_q     <= '0;
            q_addr_q     <= '0;
            d_data_q     <= '0;
            q_data_q     <= '0;
            hold_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            host_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            pend_mask_q  <= pend_mask_d;
            boot_q       <= boot_d;
            d_wen_q      <= d_wen_d;
            q_wen_q      <= q_wen_d;
            d_addr_q     <= d_addr_d;
            q_addr_q     <= q_addr_d;
            d_data_q     <= d_data_d;
            q_data_q     <= q_data_d;
            hold_q       <= hold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            host_ready_q <= host_ready_d;
        end
    end

    assign host_ready = host_ready_q;
    assign hold       = hold_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pid_d_wen  = d_wen_q;
    assign pid_q_wen  = q_wen_q;
    assign pid_d_addr = d_addr_q;
    assign pid_q_addr = q_addr_q;
    assign pid_d_data = d_data_q;
    assign pid_q_data = q_data_q;

endmodule

// File: doc/pid_coef_loader.md
Name: pid_coef_loader

Overview:
Writer side of the FOC core's PID coefficient port (pid_d_*/pid_q_* with active-low wen).
- Holds a host-programmable shadow table of NUM_COEF coefficients per axis (d, q).
- On reset (optional) or on a commit request, waits for the control loop to go idle, then streams the table into the core's PID register files.
- Sits between the host/ECU configuration path and top.

Parameters:
D_WIDTH, 19, data and address width of the pid_* ports (Q-format word).
Q_BITS, 15, fractional bits; used only for the reset defaults.
NUM_COEF, 4, coefficients per axis (addresses 0..NUM_COEF-1).
AUTO_LOAD, 1, 1 = perform a full commit of both banks immediately after reset.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
host_wr  in  1  shadow write strobe; accepted when host_wr && host_ready
host_bank  in  1  0 = d table, 1 = q table
host_addr  in  $clog2(NUM_COEF)  shadow coefficient index
host_data  in  D_WIDTH  coefficient value
host_ready  out  1  shadow accepting writes (low while streaming)
commit  in  1  single-cycle request to stream shadow to core
commit_mask  in  2  bit0 = d bank, bit1 = q bank; sampled with commit
ctrl_idle  in  1  core idle (top ready high, no valid outstanding)
hold  out  1  tells upstream sequencer to withhold valid
busy  out  1  commit in progress (WAIT_IDLE or WRITE)
done  out  1  one-cycle pulse after the last write of a commit
pid_d_wen  out  1  d-axis write enable, active low
pid_q_wen  out  1  q-axis write enable, active low
pid_d_addr  out  D_WIDTH  d-axis coefficient address
pid_q_addr  out  D_WIDTH  q-axis coefficient address
pid_d_data  out  D_WIDTH  d-axis coefficient data
pid_q_data  out  D_WIDTH  q-axis coefficient data

Behaviour:
Reset (rst high at clk edge):
- pid_*_wen = 1; pid_*_addr = 0; pid_*_data = 0.
- hold = 0, busy = 0, done = 0, host_ready = 0, pending = 0.
- Shadow defaults: idx0 = 1<<12, idx1 = 1<<9, others 0, both banks.
- Reset mid-commit aborts cleanly with no partial wen low after the reset edge.

States:
- IDLE: host_ready = 1.
  - A commit with commit_mask != 0 -> WAIT_IDLE; the mask is latched.
  - commit with mask 0 is ignored.
  - First cycle after reset with AUTO_LOAD = 1 -> WAIT_IDLE with mask 2'b11.
- WAIT_IDLE: hold = 1, busy = 1, host_ready = 0.
  - Advance to WRITE on the first cycle ctrl_idle = 1 is sampled; stay indefinitely otherwise.
- WRITE: lasts exactly NUM_COEF cycles, counter cnt = 0..NUM_COEF-1.
  - Each cycle: pid_x_addr = cnt (zero-extended) and pid_x_data = shadow[x][cnt], registered.
  - pid_x_wen = 0 only for banks in the latched mask; unselected bank keeps wen = 1, addr/data = 0.
  - ctrl_idle is ignored once WRITE is entered.
- DONE (one cycle): done = 1, all wen = 1, addr/data = 0, hold = 0, busy = 0 -> IDLE.
  - If pending = 1, go instead to WAIT_IDLE using the pending mask and clear pending; done still pulses.

Timing and latency:
- From commit in IDLE with ctrl_idle = 1: WAIT_IDLE next cycle, first wen low one cycle later.
- done asserts NUM_COEF+2 cycles after the commit cycle.

Boundary cases:
- commit while busy: pending = 1; pending mask = OR of all such masks. No commit is lost and no commit is duplicated.
- host_wr while host_ready = 0: ignored (host must hold until ready). host_wr and commit in the same IDLE cycle: the write lands first, so it is included in the commit.
- Repeat writes to the same shadow index: last write wins. Address range is power-of-two when NUM_COEF = 4; indices >= NUM_COEF are dropped.
- Outputs are fully registered; no combinational path from host_* or ctrl_idle to pid_*.

Decomposition:
- foc_pkg gets D_WIDTH, Q_BITS, NUM_COEF, coef index enum (COEF_KP = 0, COEF_KI = 1, COEF_KD = 2, COEF_KAUX = 3), default coefficient constants, loader state enum.
- One natural sub-module: pid_coef_shadow, a 2 x NUM_COEF register file with reset defaults, write port and two combinational read ports. FSM, counter and output regs stay in pid_coef_loader.

Test Plan:
- AUTO_LOAD reset, ctrl_idle = 1: after rst falls, 4 consecutive cycles with both wen = 0, addr 0..3, data 4096, 512, 0, 0. Then done pulse, wen = 1.
- Host writes d[0] = 0x02000, q[1] = 0x00100, then commit mask 2'b01: only pid_d_wen goes low, with d data 0x02000, 512, 0, 0. pid_q_wen stays 1.
- Commit with ctrl_idle = 0 for 20 cycles: hold = 1 and busy = 1 throughout, no wen low. Raise ctrl_idle: writes begin 1 cycle later.
- Commit mask 2'b10 issued during WRITE of a mask 2'b01 commit: after done, a second q-only commit runs with exactly 4 wen-low cycles and a second done.
- rst asserted during cnt = 2: next cycle all wen = 1 and addr/data = 0. Then AUTO_LOAD restarts the full sequence from addr 0 with default values.
- host_wr during WAIT_IDLE (host_ready = 0): shadow is unchanged, and the next commit streams the old value.
